// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with partial writes, write bypass and pending scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     reg_reset_n,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [1:0]               wr_mode,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] LO16 = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] LO8  = DATA_W'(8'hFF);

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         pending;
  logic [DEPTH-1:0]         pend_nxt;
  logic                     wr_hit;
  logic                     rsv_hit;
  logic [DATA_W-1:0]        wr_old;
  logic [DATA_W-1:0]        wr_merged;
  logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
  logic [NUM_RD-1:0]        rd_busy_nxt;

  assign wr_hit  = wr_en  && !(ZERO_REG && (wr_addr == '0));
  assign rsv_hit = rsv_en && !(ZERO_REG && (rsv_addr == '0));
  assign wr_old  = regs[wr_addr];

  // LUI places wr_data[15:0] at bit 16 and zero-fills anything above bit 31
  always_comb begin
    wr_merged = wr_data;
    case (wr_mode)
      2'b00:   wr_merged = wr_data;
      2'b01:   wr_merged = (wr_old & ~LO16) | DATA_W'(wr_data[15:0]);
      2'b10:   wr_merged = (wr_old & LO16) | (DATA_W'(wr_data[15:0]) << 16);
      default: wr_merged = (wr_old & ~LO8) | DATA_W'(wr_data[7:0]);
    endcase
  end

  // Reservation is applied after the write clear so a new producer stays outstanding
  always_comb begin
    pend_nxt = pending;
    if (wr_hit)
      pend_nxt[wr_addr] = 1'b0;
    if (rsv_hit)
      pend_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    ra          = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (ZERO_REG && (ra == '0)) begin
        rd_data_nxt[k*DATA_W +: DATA_W] = '0;
        rd_busy_nxt[k]                  = 1'b0;
      end else begin
        rd_data_nxt[k*DATA_W +: DATA_W] = (wr_hit && (ra == wr_addr)) ? wr_merged : regs[ra];
        rd_busy_nxt[k]                  = pend_nxt[ra];
      end
    end
  end

  always_ff @(posedge clk or negedge reg_reset_n) begin
    if (!reg_reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      pending  <= '0;
      rd_data  <= '0;
      rd_busy  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_hit)
        regs[wr_addr] <= wr_merged;
      pending  <= pend_nxt;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_data_nxt;
        rd_busy <= rd_busy_nxt;
      end
    end
  end

endmodule
